// File: rtl/pix_fetch_ctrl.sv
// pix_fetch_ctrl: fetches packed 2-bit pixels from a byte-wide synchronous ROM
// and streams them to the decoder with valid/ready handshaking. Each ROM byte
// carries four pixels, MSB pair first. Line and frame boundaries are flagged
// alongside each pixel.
module pix_fetch_ctrl #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              obj_sel,
   output logic              busy,
   output logic              done,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [1:0]        pix_data,
   output logic [2:0]        sel,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              line_end,
   output logic              frame_end
);

   localparam int NBYTES = IMG_W * IMG_H / 4;
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic              obj;
   logic [ADDR_W-1:0] addr;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [1:0]        pix_cnt;
   logic [7:0]        shreg;

   logic xfer;
   logic last_pix;
   logic last_byte;
   logic last_col;
   logic last_row;

   assign xfer      = (state == S_EMIT) && pix_ready;
   assign last_pix  = (pix_cnt == 2'd3);
   assign last_byte = (addr == ADDR_W'(NBYTES - 1));
   assign last_col  = (col == COL_W'(IMG_W - 1));
   assign last_row  = (row == ROW_W'(IMG_H - 1));
   assign rom_addr  = addr;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_REQ;
         S_REQ:  state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_EMIT;
         S_EMIT: if (xfer && last_pix) state_nxt = last_byte ? S_DONE : S_REQ;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame counters and latched object; advance only on accepted transfers
   always_ff @(posedge clk) begin
      if (rst) begin
         obj     <= 1'b0;
         addr    <= '0;
         col     <= '0;
         row     <= '0;
         pix_cnt <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  obj     <= obj_sel;
                  addr    <= '0;
                  col     <= '0;
                  row     <= '0;
                  pix_cnt <= 2'd0;
               end
            end
            S_EMIT: begin
               if (xfer) begin
                  pix_cnt <= pix_cnt + 2'd1;
                  if (last_col) begin
                     col <= '0;
                     row <= last_row ? '0 : row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
                  // Address stops at the last byte so it never wraps in a frame
                  if (last_pix && !last_byte) addr <= addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Pixel shift register: loaded from ROM in WAIT, shifted left per transfer
   always_ff @(posedge clk) begin
      if (state == S_WAIT) shreg <= rom_data;
      else if (xfer)       shreg <= {shreg[5:0], 2'b00};
   end

   // Output decode; everything is zero in IDLE
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      rom_en    = (state == S_REQ);
      pix_valid = (state == S_EMIT);
      pix_data  = 2'b00;
      line_end  = 1'b0;
      frame_end = 1'b0;
      sel       = 3'b000;
      if (state == S_EMIT) begin
         pix_data  = shreg[7:6];
         line_end  = last_col;
         frame_end = last_col && last_row;
      end
      if (state != S_IDLE) sel = obj ? 3'b110 : 3'b111;
   end

endmodule

// File: tb/tb_pix_fetch_ctrl.sv
// Directed bench for pix_fetch_ctrl on an 8x2 image (4 ROM bytes, 16 pixels).
module tb_pix_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       obj_sel;
   logic       busy;
   logic       done;
   logic       rom_en;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [1:0] pix_data;
   logic [2:0] sel;
   logic       pix_valid;
   logic       pix_ready;
   logic       line_end;
   logic       frame_end;

   int checks = 0;
   int errors = 0;

   logic [7:0] rom     [4];
   logic [1:0] exp_pix [16];

   always #5 clk = ~clk;

   pix_fetch_ctrl #(.IMG_W(8), .IMG_H(2), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .obj_sel   (obj_sel),
      .busy      (busy),
      .done      (done),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .pix_data  (pix_data),
      .sel       (sel),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   // One-cycle synchronous ROM model
   always_ff @(posedge clk) begin
      if (rom_en) rom_data <= rom[rom_addr[1:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_done"},      {31'd0, done},      32'd0);
      check({tag, "_rom_en"},    {31'd0, rom_en},    32'd0);
      check({tag, "_rom_addr"},  {28'd0, rom_addr},  32'd0);
      check({tag, "_pix_data"},  {30'd0, pix_data},  32'd0);
      check({tag, "_sel"},       {29'd0, sel},       32'd0);
      check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
      check({tag, "_line_end"},  {31'd0, line_end},  32'd0);
      check({tag, "_frame_end"}, {31'd0, frame_end}, 32'd0);
   endtask

   // Runs one frame from a start pulse; optional stall, mid-frame start, or reset at a pixel
   task automatic run_frame(input logic obj, input int stall_at, input int stall_len,
                            input bit mid_start, input int rst_at);
      int         cyc;
      int         n;
      int         nrom;
      int         stall_cnt;
      int         first_v;
      bit         got_done;
      bit         did_rst;
      logic [2:0] exp_sel;
      logic [1:0] held;
      exp_sel   = obj ? 3'b110 : 3'b111;
      n         = 0;
      nrom      = 0;
      stall_cnt = 0;
      first_v   = -1;
      got_done  = 1'b0;
      did_rst   = 1'b0;
      held      = 2'b00;
      start     = 1'b1;
      obj_sel   = obj;
      pix_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (cyc < 80) begin
         pix_ready = 1'b1;
         if (mid_start && cyc == 10) begin
            start   = 1'b1;
            obj_sel = ~obj;
         end else begin
            start = 1'b0;
         end
         if (cyc == 1) check("first_busy", {31'd0, busy}, 32'd1);
         check("sel_busy", {29'd0, sel}, {29'd0, exp_sel});
         if (rom_en) begin
            check("rom_addr_seq", {28'd0, rom_addr}, nrom);
            nrom++;
         end
         if (pix_valid) begin
            if (first_v < 0) first_v = cyc;
            if (n == rst_at) begin
               rst     = 1'b1;
               did_rst = 1'b1;
               break;
            end
            if (n == stall_at && stall_cnt < stall_len) begin
               pix_ready = 1'b0;
               if (stall_cnt == 0) held = pix_data;
               else check("stall_hold", {30'd0, pix_data}, {30'd0, held});
               check("stall_pix", {30'd0, pix_data}, {30'd0, exp_pix[n]});
               stall_cnt++;
            end else begin
               check("pix_data", {30'd0, pix_data}, {30'd0, exp_pix[n]});
               check("line_end", {31'd0, line_end}, {31'd0, (n == 7 || n == 15)});
               check("frame_end", {31'd0, frame_end}, {31'd0, (n == 15)});
               n++;
            end
         end else begin
            check("pix_idle", {30'd0, pix_data}, 32'd0);
         end
         if (done) begin
            got_done = 1'b1;
            check("done_cycle", cyc, 25 + stall_len);
            check("pix_count", n, 16);
            check("rom_reads", nrom, 4);
            check("first_valid", first_v, 3);
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (did_rst) begin
         @(posedge clk); #1;
         rst = 1'b0;
         check_idle_outputs("mid_rst");
      end else if (!got_done) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk); #1;
         check("busy_after", {31'd0, busy}, 32'd0);
         check("done_single", {31'd0, done}, 32'd0);
         check("sel_after", {29'd0, sel}, 32'd0);
      end
      pix_ready = 1'b1;
   endtask

   initial begin
      rom[0] = 8'b00110110;
      rom[1] = 8'b11100100;
      rom[2] = 8'b00011011;
      rom[3] = 8'b10011100;
      exp_pix = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                  2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0};
      rst       = 1'b1;
      start     = 1'b0;
      obj_sel   = 1'b0;
      pix_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("idle");

      // Plain logo frame
      run_frame(1'b0, -1, 0, 1'b0, -1);
      // Backpressure at pixel 2 for 3 cycles
      run_frame(1'b0, 2, 3, 1'b0, -1);
      // Start pulse and obj_sel toggle mid-frame
      run_frame(1'b0, -1, 0, 1'b1, -1);
      obj_sel = 1'b0;
      // Reset at pixel 9, then a cubes frame
      run_frame(1'b0, -1, 0, 1'b0, 9);
      run_frame(1'b1, -1, 0, 1'b0, -1);

      // Reset wins over start
      rst     = 1'b1;
      start   = 1'b1;
      obj_sel = 1'b1;
      @(posedge clk); #1;
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      check("rst_start_sel", {29'd0, sel}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      check("rst_start_busy2", {31'd0, busy}, 32'd0);
      check("rst_start_rom_en", {31'd0, rom_en}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pix_fetch_ctrl.md
PIX_FETCH_CTRL -- requirements
Module: pix_fetch_ctrl

Interface
REQ-001 Parameter IMG_W, default 64, pixels per line; SHALL be a multiple of 4.
REQ-002 Parameter IMG_H, default 64, lines per frame.
REQ-003 Parameter ADDR_W, default 10, ROM address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H/4.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  frame request, sampled in IDLE only.
REQ-007 obj_sel  in  1  object select, 0 = logo, 1 = cubes; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at frame completion.
REQ-010 rom_en  out  1  ROM read strobe.
REQ-011 rom_addr  out  ADDR_W  ROM byte address.
REQ-012 rom_data  in  8  ROM byte, valid the cycle after rom_en (1-cycle synchronous read).
REQ-013 pix_data  out  2  encoded pixel to decoder.
REQ-014 sel  out  3  decoder select: 3'b111 logo, 3'b110 cubes, 3'b000 when not busy.
REQ-015 pix_valid  out  1  pix_data/sel/line_end/frame_end valid.
REQ-016 pix_ready  in  1  downstream accepts the pixel.
REQ-017 line_end  out  1  qualifies the last pixel of each line.
REQ-018 frame_end  out  1  qualifies the last pixel of the frame.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, EMIT, DONE.
REQ-020 IDLE: start=1 SHALL latch obj_sel, clear rom_addr, pixel, line and byte counters to 0, and go to REQ.
REQ-021 REQ: rom_en=1 for exactly one cycle at the current rom_addr, then go to WAIT.
REQ-022 WAIT: rom_data SHALL be captured into a 4-pixel shift register and the FSM SHALL go to EMIT.
REQ-023 Byte packing: first pixel is rom_data[7:6], then [5:4], [3:2], [1:0].
REQ-024 EMIT: pix_valid=1. A transfer occurs on a cycle with pix_valid&pix_ready; each transfer advances one pixel.
REQ-025 While pix_valid=1 and pix_ready=0, pix_data, sel, line_end and frame_end SHALL hold stable.
REQ-026 After the 4th transfer of a byte: if it was the last byte (IMG_W*IMG_H/4 bytes), go to DONE; otherwise increment rom_addr and go to REQ.
REQ-027 Fixed cost per byte with pix_ready=1: 6 cycles (REQ, WAIT, 4 EMIT). The first pix_valid SHALL occur 3 cycles after the edge that samples start.
REQ-028 DONE: done=1 for one cycle, then go to IDLE; busy SHALL fall with the IDLE entry.
REQ-029 line_end SHALL be 1 when the column counter equals IMG_W-1. The column counter wraps to 0 after each line-end transfer.
REQ-030 frame_end SHALL be 1 on the pixel where line_end=1 and the row counter equals IMG_H-1.
REQ-031 start SHALL be ignored while busy. obj_sel changes after capture SHALL have no effect until the next frame.
REQ-032 pix_data SHALL be 2'b00 and pix_valid 0 outside EMIT.
REQ-033 sel SHALL equal the latched object code in all busy states, and 3'b000 in IDLE.
REQ-034 rom_addr SHALL never exceed IMG_W*IMG_H/4-1 and SHALL not wrap within a frame.

Reset
REQ-035 rst=1 at any clock edge, including mid-frame, SHALL force IDLE and drive the following outputs to 0: busy, done, rom_en, rom_addr, pix_data, sel, pix_valid, line_end, frame_end. All counters and the latched object SHALL clear.
REQ-036 rst SHALL take priority over start when both are high.

Verification (IMG_W=8, IMG_H=2, ADDR_W=4: 4 bytes, 16 pixels)
REQ-037 Reset then idle -> all outputs 0, sel=3'b000, busy=0.
REQ-038 Logo frame, start=1, obj_sel=0, pix_ready=1, ROM byte0=8'b00110110 -> pixels 00,11,01,10 with sel=3'b111.
  - 16 pixels total; line_end on pixels 7 and 15; frame_end on pixel 15 only.
  - rom_addr sequence 0,1,2,3; done pulse 25 cycles after start.
REQ-039 Backpressure: pix_ready=0 for 3 cycles at pixel 2 -> pix_data/sel held; no pixel lost or duplicated; frame extends by 3 cycles.
REQ-040 start pulsed and obj_sel toggled mid-frame -> ignored; sel stays 3'b111; exactly one done.
REQ-041 rst=1 at pixel 9, then cubes frame (obj_sel=1) -> outputs cleared the next cycle; new frame restarts at rom_addr=0 with sel=3'b110.
REQ-042 start=1 and rst=1 in the same cycle -> stays IDLE, busy=0.
